// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LEGv8 instruction fetch stage: PC, IMem handshake, Imm26/SignCtrl predecode
// Holds one fetched instruction with its predecoded sign-extender control until downstream consumes it.

module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [63:0] BranchPC,
   input  logic [63:0] BusImm,
   output logic        IMemReq,
   output logic [63:0] IMemAddr,
   input  logic        IMemRdy,
   input  logic [31:0] IMemData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [63:0] InstrPC,
   output logic [25:0] Imm26,
   output logic [2:0]  SignCtrl
);

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [2:0] SC_DTYPE = 3'd0;
   localparam logic [2:0] SC_CBZ   = 3'd1;
   localparam logic [2:0] SC_B     = 3'd2;
   localparam logic [2:0] SC_ITYPE = 3'd3;
   localparam logic [2:0] SC_MOVZ  = 3'd4;

   state_t      state_q;
   logic [63:0] pc_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [63:0] ipc_q;
   logic [25:0] imm_q;
   logic [2:0]  ctrl_q;

   logic [63:0] pc_inc_d;
   logic [63:0] target_d;
   logic [2:0]  ctrl_d;
   logic        req;
   logic        accept;
   logic        consume;

   function automatic logic [2:0] decode_ctrl(input logic [31:0] w);
      logic [2:0] c;
      c = SC_DTYPE;
      if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0)
         c = SC_DTYPE;
      else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5)
         c = SC_CBZ;
      else if (w[31:26] == 6'h05 || w[31:26] == 6'h25)
         c = SC_B;
      else if (w[31:22] == 10'h244 || w[31:22] == 10'h248 || w[31:22] == 10'h2C8 ||
               w[31:22] == 10'h344 || w[31:22] == 10'h348)
         c = SC_ITYPE;
      else if (w[31:23] == 9'h1A5)
         c = SC_MOVZ;
      return c;
   endfunction

   // Both adders wrap modulo 2^64; misaligned targets are fetched as-is.
   assign pc_inc_d = pc_q + 64'd4;
   assign target_d = BranchPC + BusImm;
   assign ctrl_d   = decode_ctrl(IMemData);

   // A held instruction blocks new requests only while downstream is stalled.
   assign req     = (state_q == ST_FETCH) && (!valid_q || !Stall);
   assign accept  = req && IMemRdy && !BranchTaken;
   assign consume = valid_q && !Stall;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         ipc_q   <= 64'h0;
         imm_q   <= 26'h0;
         ctrl_q  <= 3'h0;
      end else if (BranchTaken) begin
         state_q <= ST_REDIRECT;
         pc_q    <= target_d;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (accept) begin
                  instr_q <= IMemData;
                  ipc_q   <= pc_q;
                  imm_q   <= IMemData[25:0];
                  ctrl_q  <= ctrl_d;
                  valid_q <= 1'b1;
                  pc_q    <= pc_inc_d;
               end else if (consume) begin
                  valid_q <= 1'b0;
               end
            end
            ST_REDIRECT: begin
               state_q <= ST_FETCH;
            end
            default: begin
               state_q <= ST_BOOT;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign IMemReq    = req;
   assign IMemAddr   = pc_q;
   assign InstrValid = valid_q;
   assign Instr      = instr_q;
   assign InstrPC    = ipc_q;
   assign Imm26      = imm_q;
   assign SignCtrl   = ctrl_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a bubble-counting reference model
// Model compared every negedge; literal checks pin the model at key points.

module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        BranchTaken;
   logic [63:0] BranchPC;
   logic [63:0] BusImm;
   logic        IMemReq;
   logic [63:0] IMemAddr;
   logic        IMemRdy;
   logic [31:0] IMemData;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [63:0] InstrPC;
   logic [25:0] Imm26;
   logic [2:0]  SignCtrl;

   int checks = 0;
   int errors = 0;

   logic [31:0] imem [16];

   always #5 CLK = ~CLK;

   assign IMemData = imem[IMemAddr[5:2]];

   fetch_unit #(.RESET_PC(64'h100)) dut (
      .CLK(CLK), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
      .BranchPC(BranchPC), .BusImm(BusImm), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemRdy(IMemRdy), .IMemData(IMemData), .InstrValid(InstrValid), .Instr(Instr),
      .InstrPC(InstrPC), .Imm26(Imm26), .SignCtrl(SignCtrl)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Opcode table: first rule whose masked bits match wins; no match means D-type.
   localparam int NR = 12;
   localparam logic [31:0] R_MASK [NR] = '{
      32'hFFE00000, 32'hFFE00000, 32'hFF000000, 32'hFF000000, 32'hFC000000, 32'hFC000000,
      32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFF800000};
   localparam logic [31:0] R_MATCH [NR] = '{
      32'hF8400000, 32'hF8000000, 32'hB4000000, 32'hB5000000, 32'h14000000, 32'h94000000,
      32'h91000000, 32'h92000000, 32'hB2000000, 32'hD1000000, 32'hD2000000, 32'hD2800000};
   localparam logic [2:0] R_CTRL [NR] = '{
      3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};

   function automatic logic [2:0] ref_ctrl(input logic [31:0] w);
      for (int r = 0; r < NR; r++)
         if ((w & R_MASK[r]) == R_MATCH[r]) return R_CTRL[r];
      return 3'd0;
   endfunction

   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr;
   logic        m_valid;
   int          m_bubble;

   function automatic logic m_req();
      return (m_bubble == 0) && (!m_valid || !Stall);
   endfunction

   always @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         m_pc = 64'h100; m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_bubble = 1;
      end else if (BranchTaken) begin
         m_pc = BranchPC + BusImm; m_valid = 1'b0; m_bubble = 1;
      end else if (m_bubble > 0) begin
         m_bubble--;
      end else if (m_req() && IMemRdy) begin
         m_instr = IMemData; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end else if (m_valid && !Stall) begin
         m_valid = 1'b0;
      end
   end

   always @(negedge CLK) begin
      chk("m_req", {63'h0, IMemReq}, {63'h0, m_req()});
      if (m_req()) chk("m_addr", IMemAddr, m_pc);
      chk("m_valid", {63'h0, InstrValid}, {63'h0, m_valid});
      chk("m_instr", {32'h0, Instr}, {32'h0, m_instr});
      chk("m_ipc", InstrPC, m_ipc);
      chk("m_imm26", {38'h0, Imm26}, {38'h0, m_instr[25:0]});
      chk("m_ctrl", {61'h0, SignCtrl}, {61'h0, ref_ctrl(m_instr)});
   end

   task automatic nxt();
      @(negedge CLK);
      #1;
   endtask

   logic [2:0]  exp_ctrl [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
   logic [31:0] w;

   initial begin
      imem = '{32'hF8400000, 32'hB4000040, 32'h14000003, 32'h91000400, 32'hD2800020,
               32'h8B000000, 32'h94000010, 32'hB5000123, 32'hB2000FFF, 32'hD1000004,
               32'hD2000008, 32'hF8000010, 32'h92000001, 32'hD2FFFFFF, 32'h00000000,
               32'hAA0203E1};
      Reset = 0; Stall = 0; BranchTaken = 0; BranchPC = 0; BusImm = 0; IMemRdy = 1;
      #1 Reset = 1;
      nxt();
      chk("rst_req", {63'h0, IMemReq}, 64'h0);
      chk("rst_valid", {63'h0, InstrValid}, 64'h0);
      chk("rst_instr", {32'h0, Instr}, 64'h0);
      chk("rst_ctrl", {61'h0, SignCtrl}, 64'h0);
      Reset = 0;
      nxt();
      chk("boot_addr", IMemAddr, 64'h100);
      chk("boot_req", {63'h0, IMemReq}, 64'h1);
      nxt();
      chk("s_addr1", IMemAddr, 64'h104);
      chk("s_ipc1", InstrPC, 64'h100);
      nxt();
      chk("s_addr2", IMemAddr, 64'h108);
      chk("s_ipc2", InstrPC, 64'h104);
      chk("s_valid2", {63'h0, InstrValid}, 64'h1);
      IMemRdy = 0;
      nxt();
      chk("wait_valid", {63'h0, InstrValid}, 64'h0);
      chk("wait_addr1", IMemAddr, 64'h108);
      nxt();
      chk("wait_addr2", IMemAddr, 64'h108);
      IMemRdy = 1;
      nxt();
      chk("resume_ipc", InstrPC, 64'h108);
      Stall = 1;
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk("stall_req", {63'h0, IMemReq}, 64'h0);
         chk("stall_ipc", InstrPC, 64'h108);
         chk("stall_instr", {32'h0, Instr}, {32'h0, imem[2]});
      end
      Stall = 0;
      nxt();
      chk("unstall_ipc", InstrPC, 64'h10C);
      BranchTaken = 1; BranchPC = 64'h10; BusImm = 64'hFFFF_FFFF_FFFF_FFF8;
      nxt();
      chk("br_valid", {63'h0, InstrValid}, 64'h0);
      chk("br_bubble", {63'h0, IMemReq}, 64'h0);
      BranchTaken = 0;
      nxt();
      chk("br_addr", IMemAddr, 64'h8);
      nxt();
      chk("br_ipc", InstrPC, 64'h8);
      BranchTaken = 1; BranchPC = 64'h40; BusImm = 64'h20;
      nxt();
      BranchPC = 64'h0; BusImm = 64'hFFFF_FFFF_FFFF_FFFC;
      nxt();
      chk("rebr_bubble", {63'h0, IMemReq}, 64'h0);
      BranchTaken = 0;
      nxt();
      chk("wrap_addr0", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      nxt();
      chk("wrap_addr1", IMemAddr, 64'h0);
      for (int i = 0; i < 6; i++) begin
         nxt();
         w = imem[i];
         chk("dec_ipc", InstrPC, 64'(i * 4));
         chk("dec_ctrl", {61'h0, SignCtrl}, {61'h0, exp_ctrl[i]});
         chk("dec_imm", {38'h0, Imm26}, {38'h0, w[25:0]});
      end
      #2 Reset = 1;
      #1;
      chk("mid_valid", {63'h0, InstrValid}, 64'h0);
      chk("mid_instr", {32'h0, Instr}, 64'h0);
      chk("mid_ipc", InstrPC, 64'h0);
      chk("mid_req", {63'h0, IMemReq}, 64'h0);
      nxt();
      Reset = 0;
      nxt();
      chk("post_addr", IMemAddr, 64'h100);
      nxt();
      chk("post_ipc", InstrPC, 64'h100);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
